// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP master: FSM states, DRP addresses,
// and the configuration table written after reset.
package xadc_pkg;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned INIT_LEN = 3;
  localparam int unsigned IDX_W    = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  localparam logic [ADDR_W-1:0] CFG0  = 7'h40;
  localparam logic [ADDR_W-1:0] CFG1  = 7'h41;
  localparam logic [ADDR_W-1:0] CFG2  = 7'h42;
  localparam logic [ADDR_W-1:0] VAUX6 = 7'h16;

  localparam logic [DATA_W-1:0] DEAD_WORD = 16'hDEAD;

  typedef enum logic [2:0] {
    INIT_ISSUE,
    INIT_WAIT,
    IDLE,
    SMP_WAIT,
    HOST_WAIT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } drp_entry_t;

  // VAUX6 without averaging, single-channel mode with alarms off, DCLK divide 4
  localparam drp_entry_t INIT_TABLE [INIT_LEN] = '{
    '{addr: CFG0, data: 16'h0016},
    '{addr: CFG1, data: 16'h3F0F},
    '{addr: CFG2, data: 16'h0400}
  };

endpackage

// File: rtl/drp_timeout_counter.sv
// Counts DCLK cycles of an outstanding DRP transaction; expired_c flags the last
// allowed cycle before the transaction is abandoned.
module drp_timeout_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign expired_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Saturates at the expiry value so a stuck enable never wraps around
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/xadc_drp_master.sv
// DRP initiator for the XADC: writes the init table, reads the channel status on
// every eoc, and arbitrates a host register port onto the same DRP.
module xadc_drp_master
  import xadc_pkg::*;
#(
  parameter logic [6:0]  CHANNEL_ADDR = VAUX6,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        eoc,
  output logic        den,
  output logic        dwe,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  input  logic [15:0] do_in,
  input  logic        drdy,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        init_done,
  output logic        timeout_err,
  output logic        overrun
);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pending_q, pending_d;

  logic                  den_d, dwe_d;
  logic [ADDR_W-1:0]     daddr_d;
  logic [DATA_W-1:0]     di_d;
  logic                  host_ack_d;
  logic [DATA_W-1:0]     host_rdata_d;
  logic [SAMPLE_W-1:0]   sample_d;
  logic                  sample_valid_d;
  logic                  init_done_d, timeout_err_d, overrun_d;

  logic                  serve_c;
  logic                  tmo_clear_c;
  logic                  tmo_enable_c;
  logic                  tmo_expired_c;

  assign tmo_enable_c = (state_q == INIT_WAIT) || (state_q == SMP_WAIT) ||
                        (state_q == HOST_WAIT);

  drp_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (tmo_clear_c),
    .enable    (tmo_enable_c),
    .expired_c (tmo_expired_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT_ISSUE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      den          <= 1'b0;
      dwe          <= 1'b0;
      daddr        <= '0;
      di           <= '0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      init_done    <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      den          <= den_d;
      dwe          <= dwe_d;
      daddr        <= daddr_d;
      di           <= di_d;
      host_ack     <= host_ack_d;
      host_rdata   <= host_rdata_d;
      sample       <= sample_d;
      sample_valid <= sample_valid_d;
      init_done    <= init_done_d;
      timeout_err  <= timeout_err_d;
      overrun      <= overrun_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    pending_d      = pending_q;
    den_d          = 1'b0;
    dwe_d          = dwe;
    daddr_d        = daddr;
    di_d           = di;
    host_ack_d     = 1'b0;
    host_rdata_d   = host_rdata;
    sample_d       = sample;
    sample_valid_d = 1'b0;
    init_done_d    = init_done;
    timeout_err_d  = timeout_err;
    overrun_d      = overrun;
    tmo_clear_c    = 1'b0;

    // A fresh eoc in IDLE is served directly; one arriving as a held one is
    // consumed becomes the new pending entry rather than an overrun.
    serve_c = (state_q == IDLE) && (pending_q || eoc);
    if (serve_c) begin
      pending_d = pending_q && eoc;
    end else if (eoc) begin
      pending_d = 1'b1;
      if (pending_q) begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      INIT_ISSUE: begin
        den_d       = 1'b1;
        dwe_d       = 1'b1;
        daddr_d     = INIT_TABLE[idx_q].addr;
        di_d        = INIT_TABLE[idx_q].data;
        tmo_clear_c = 1'b1;
        state_d     = INIT_WAIT;
      end

      INIT_WAIT: begin
        if (drdy || tmo_expired_c) begin
          dwe_d = 1'b0;
          if (!drdy) begin
            timeout_err_d = 1'b1;
          end
          if (idx_q == IDX_W'(INIT_LEN - 1)) begin
            idx_d       = '0;
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = INIT_ISSUE;
          end
        end
      end

      IDLE: begin
        if (serve_c) begin
          den_d       = 1'b1;
          dwe_d       = 1'b0;
          daddr_d     = CHANNEL_ADDR;
          di_d        = '0;
          tmo_clear_c = 1'b1;
          state_d     = SMP_WAIT;
        end else if (host_req && !host_ack) begin
          // host_ack still high means the host has not yet seen its completion
          den_d       = 1'b1;
          dwe_d       = host_we;
          daddr_d     = host_addr;
          di_d        = host_we ? host_wdata : '0;
          tmo_clear_c = 1'b1;
          state_d     = HOST_WAIT;
        end
      end

      SMP_WAIT: begin
        if (drdy) begin
          sample_d       = do_in[15:4];
          sample_valid_d = 1'b1;
          dwe_d          = 1'b0;
          state_d        = IDLE;
        end else if (tmo_expired_c) begin
          timeout_err_d = 1'b1;
          dwe_d         = 1'b0;
          state_d       = IDLE;
        end
      end

      HOST_WAIT: begin
        if (drdy) begin
          host_rdata_d = dwe ? '0 : do_in;
          host_ack_d   = 1'b1;
          dwe_d        = 1'b0;
          state_d      = IDLE;
        end else if (tmo_expired_c) begin
          host_rdata_d  = DEAD_WORD;
          host_ack_d    = 1'b1;
          timeout_err_d = 1'b1;
          dwe_d         = 1'b0;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = INIT_ISSUE;
      end
    endcase
  end

endmodule

// File: doc/xadc_drp_master.md
Name: xadc_drp_master

Overview:
- DRP initiator for the XADC wizard's dynamic reconfiguration port, replacing the eoc-to-den loopback.
- After reset, writes a fixed configuration table into the XADC.
- Then reads the VAUX6 status register on every end-of-conversion and presents a registered 12-bit sample.
- Also arbitrates one host register-access port onto the same DRP, with a drdy timeout and overrun detection.

Parameters:
- CHANNEL_ADDR, 7'h16: DRP status address read on each eoc (VAUX6).
- TIMEOUT, 64: DCLK cycles allowed from den to drdy before the transaction is abandoned.
- INIT_LEN, 3: number of entries in the init table.

Ports:
- CLK  in  1  100 MHz clock, also drives XADC dclk.
- RST_N  in  1  asynchronous active-low reset.
- eoc  in  1  XADC eoc_out, one-cycle pulse.
- den  out  1  DRP enable.
- dwe  out  1  DRP write enable.
- daddr  out  7  DRP address.
- di  out  16  DRP write data.
- do_in  in  16  DRP read data.
- drdy  in  1  DRP ready.
- host_req  in  1  host access request, level.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  7  host DRP address.
- host_wdata  in  16  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  16  read data, valid with host_ack.
- sample  out  12  do_in[15:4] of the last channel read.
- sample_valid  out  1  one-cycle pulse.
- init_done  out  1  high once the init table is written.
- timeout_err  out  1  sticky.
- overrun  out  1  sticky, a conversion was lost.

Behaviour:
- Reset (async, RST_N low): all outputs 0. State INIT_ISSUE, table index 0, pending flag cleared. Sticky flags clear only on reset.
- States: INIT_ISSUE, INIT_WAIT, IDLE, SMP_WAIT, HOST_WAIT.
- Issue rule: den high for exactly one cycle. daddr, di and dwe are driven that cycle and held stable until drdy or timeout. Timeout counter starts at 0 on the issue cycle.
- INIT_ISSUE: write table[index] (dwe=1), then go to INIT_WAIT.
- INIT_WAIT on drdy: index+1. If index == INIT_LEN-1, set init_done and go to IDLE; else go to INIT_ISSUE.
- Init table:
  - 0x40 = 16'h0016 (VAUX6, no averaging)
  - 0x41 = 16'h3F0F (single-channel mode, alarms off)
  - 0x42 = 16'h0400 (DCLK divide 4)
- IDLE priority: pending eoc is served before host_req. Read CHANNEL_ADDR (dwe=0) and go to SMP_WAIT; else, if host_req, issue the host transaction and go to HOST_WAIT.
- SMP_WAIT on drdy: sample <= do_in[15:4]; sample_valid pulses the cycle after drdy; return to IDLE.
- HOST_WAIT on drdy: host_rdata <= do_in (write: 16'h0000); host_ack pulses the cycle after drdy; return to IDLE.
  - host_req must stay high until host_ack; a drop earlier is a protocol violation.
- eoc handling: eoc in any state sets pending (one deep). Pending clears on the issue cycle of the sample read. eoc while pending already set → overrun <= 1 and the extra eoc is dropped.
  - eoc and the pending clear in the same cycle leave pending set, with no overrun.
- eoc during init: latched in pending and served after init_done.
- Timeout: counter reaches TIMEOUT-1 without drdy → timeout_err <= 1.
  - Init: advance to the next entry.
  - Sample: no sample_valid.
  - Host: host_ack still pulses, with host_rdata = 16'hDEAD.
  - Then IDLE.
- drdy in IDLE (spurious): ignored.
- Reset mid-transaction: den/dwe drop immediately; init restarts from index 0.
- Throughput: one transaction in flight; back-to-back issue is allowed on the cycle after completion.

Decomposition:
- Package xadc_pkg holds:
  - state enum;
  - DRP address constants (CFG0 = 7'h40, CFG1 = 7'h41, CFG2 = 7'h42, VAUX6 = 7'h16);
  - init table array of {addr, data};
  - DEAD_WORD = 16'hDEAD.
- Sub-module drp_timeout_counter: clear/enable/expired signals, width clog2(TIMEOUT).
- The FSM remains in xadc_drp_master.

Test Plan:
1. Reset release, drdy returned 2 cycles after each den → writes 0x40/0016, 0x41/3F0F, 0x42/0400 in order, each den one cycle wide; init_done rises the cycle after the third drdy.
2. After init, eoc pulse, drdy with do_in = 16'hABC5 → den with daddr = 7'h16, dwe = 0; sample = 12'hABC, sample_valid one cycle.
3. host_req read of 0x41 asserted the same cycle as eoc → sample read issued first, host read next; host_ack with host_rdata = do_in; no overrun.
4. Two eoc pulses while a host transaction holds the DRP (drdy delayed 10 cycles) → overrun = 1; exactly one sample read follows.
5. drdy withheld → den then exactly 64 cycles; timeout_err = 1; host_ack with host_rdata = 16'hDEAD; next transaction issues normally.
6. RST_N low during INIT_WAIT of entry 2 → outputs 0 asynchronously; after release, init restarts at address 0x40.
